// File: rtl/cache_axi_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_axi_arbiter_pkg
// Shared AXI4 types and constants for the cache-to-AXI arbiter.
//   axi_m_t : everything the master drives (AR*, RREADY, AW*, W*, BREADY)
//   axi_s_t : everything the slave drives (ARREADY, R*, AWREADY, WREADY, B*)
//   rd_state_e / wr_state_e : read and write sequencer states
//   same_word() : compares two byte addresses at 32-bit word granularity
// ---------------------------------------------------------------------------
package cache_axi_arbiter_pkg;

  localparam int         AXI_ID_W       = 4;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW_W = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                rready;
    logic [AXI_ID_W-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                bready;
  } axi_m_t;

  typedef struct packed {
    logic                arready;
    logic [AXI_ID_W-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                awready;
    logic                wready;
    logic [AXI_ID_W-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
  } axi_s_t;

  // True when both byte addresses fall in the same 32-bit word.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return (a[31:2] == b[31:2]);
  endfunction

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_axi_arbiter_if
// AXI4 master-port bundle between the arbiter and the top-level AXI wrapper.
//   axi_m_o : master-driven channel signals
//   axi_s_i : slave-driven channel signals
// Modports: master (arbiter side), slave (wrapper / memory model side).
// ---------------------------------------------------------------------------
interface cache_axi_arbiter_if;
  import cache_axi_arbiter_pkg::*;

  axi_m_t axi_m_o;
  axi_s_t axi_s_i;

  modport master (output axi_m_o, input axi_s_i);
  modport slave  (input axi_m_o, output axi_s_i);
endinterface

// File: rtl/cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// cache_axi_arbiter
// Shares one AXI4 master port between I-cache refill, D-cache refill and the
// D-cache write-through path. One read and one write may be in flight at
// once; a data read to a word with a pending write is held back.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   i_req/i_addr/i_len      inst refill request, i_gnt one-cycle capture pulse
//   d_req/d_addr/d_len      data refill request, d_gnt one-cycle capture pulse
//   rd_valid/data/last/owner  read beats forwarded from R (owner 0 inst, 1 data)
//   w_req/w_addr/w_data/w_strb  write-through request, w_gnt capture pulse
//   w_done                  one-cycle pulse on the B handshake
//   axi                     AXI4 master port (master modport)
// ---------------------------------------------------------------------------
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter int   LEN_W   = 4,
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              i_gnt,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [LEN_W-1:0]  d_len,
  output logic              d_gnt,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              rd_last,
  output logic              rd_owner,
  input  logic              w_req,
  input  logic [31:0]       w_addr,
  input  logic [31:0]       w_data,
  input  logic [3:0]        w_strb,
  output logic              w_gnt,
  output logic              w_done,
  cache_axi_arbiter_if.master axi
);

  rd_state_e        r_state_r;
  logic             rr_ptr_r;      // 0: data has priority on a tie, 1: inst
  logic [31:0]      ar_addr_r;
  logic [LEN_W-1:0] ar_len_r;
  logic             arvalid_r;
  logic             rd_owner_r;
  logic             i_gnt_r;
  logic             d_gnt_r;

  wr_state_e        w_state_r;
  logic [31:0]      w_addr_r;
  logic [31:0]      w_data_r;
  logic [3:0]       w_strb_r;
  logic             awvalid_r;
  logic             wvalid_r;
  logic             bready_r;
  logic             w_gnt_r;
  logic             w_done_r;

  logic             raw_busy_s;
  logic             raw_new_s;
  logic             d_elig_s;
  logic             pick_d_s;
  logic             pick_i_s;
  logic             aw_ok_s;
  logic             w_ok_s;
  axi_m_t           m_s;
  logic             unused_ok_s;

  // A data read may not overtake a write to the same word, whether that
  // write is already latched or is being captured this very cycle.
  assign raw_busy_s = (w_state_r != W_IDLE) && same_word(d_addr, w_addr_r);
  assign raw_new_s  = w_req && same_word(d_addr, w_addr);
  assign d_elig_s   = d_req && !raw_busy_s && !raw_new_s;

  // Round-robin pick: data wins when alone or when it holds priority.
  assign pick_d_s   = d_elig_s && (!i_req || (rr_ptr_r == 1'b0));
  assign pick_i_s   = i_req && !pick_d_s;

  // Each write handshake counts as done once it has happened or happens now.
  assign aw_ok_s    = !awvalid_r || axi.axi_s_i.awready;
  assign w_ok_s     = !wvalid_r  || axi.axi_s_i.wready;

  // Read sequencer: arbitration, AR issue and burst tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_r  <= R_IDLE;
      rr_ptr_r   <= RR_INIT;
      ar_addr_r  <= 32'h0000_0000;
      ar_len_r   <= '0;
      arvalid_r  <= 1'b0;
      rd_owner_r <= 1'b0;
      i_gnt_r    <= 1'b0;
      d_gnt_r    <= 1'b0;
    end else begin
      i_gnt_r <= 1'b0;
      d_gnt_r <= 1'b0;
      case (r_state_r)
        R_IDLE: begin
          if (pick_i_s || pick_d_s) begin
            r_state_r  <= R_AR;
            arvalid_r  <= 1'b1;
            ar_addr_r  <= pick_d_s ? d_addr : i_addr;
            ar_len_r   <= pick_d_s ? d_len : i_len;
            rd_owner_r <= pick_d_s;
            i_gnt_r    <= pick_i_s;
            d_gnt_r    <= pick_d_s;
            // Priority passes to the requester that just lost.
            rr_ptr_r   <= pick_d_s;
          end
        end
        R_AR: begin
          if (axi.axi_s_i.arready) begin
            arvalid_r <= 1'b0;
            r_state_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.axi_s_i.rvalid && axi.axi_s_i.rlast) begin
            r_state_r <= R_IDLE;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arvalid_r <= 1'b0;
        end
      endcase
    end
  end

  // Write sequencer: capture, independent AW/W handshakes, then B.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_r <= W_IDLE;
      w_addr_r  <= 32'h0000_0000;
      w_data_r  <= 32'h0000_0000;
      w_strb_r  <= 4'h0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      w_gnt_r   <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      w_gnt_r  <= 1'b0;
      w_done_r <= 1'b0;
      case (w_state_r)
        W_IDLE: begin
          if (w_req) begin
            w_state_r <= W_AW_W;
            w_addr_r  <= w_addr;
            w_data_r  <= w_data;
            w_strb_r  <= w_strb;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            w_gnt_r   <= 1'b1;
          end
        end
        W_AW_W: begin
          if (axi.axi_s_i.awready) begin
            awvalid_r <= 1'b0;
          end
          if (axi.axi_s_i.wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_ok_s && w_ok_s) begin
            w_state_r <= W_B;
            bready_r  <= 1'b1;
          end
        end
        W_B: begin
          if (axi.axi_s_i.bvalid) begin
            bready_r  <= 1'b0;
            w_done_r  <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
        end
      endcase
    end
  end

  // Assemble the master-side AXI bundle; fixed fields are tied off here.
  always_comb begin
    m_s         = '0;
    m_s.arid    = '0;
    m_s.araddr  = ar_addr_r;
    m_s.arlen   = 8'(ar_len_r);
    m_s.arsize  = AXI_SIZE_4B;
    m_s.arburst = AXI_BURST_INCR;
    m_s.arvalid = arvalid_r;
    m_s.rready  = (r_state_r == R_DATA);
    m_s.awid    = '0;
    m_s.awaddr  = w_addr_r;
    m_s.awlen   = 8'd0;
    m_s.awsize  = AXI_SIZE_4B;
    m_s.awburst = AXI_BURST_INCR;
    m_s.awvalid = awvalid_r;
    m_s.wdata   = w_data_r;
    m_s.wstrb   = w_strb_r;
    m_s.wlast   = 1'b1;
    m_s.wvalid  = wvalid_r;
    m_s.bready  = bready_r;
  end

  assign axi.axi_m_o = m_s;

  // Read beats are forwarded with no added latency.
  assign rd_valid = axi.axi_s_i.rvalid && (r_state_r == R_DATA);
  assign rd_data  = axi.axi_s_i.rdata;
  assign rd_last  = axi.axi_s_i.rlast;
  assign rd_owner = rd_owner_r;

  assign i_gnt  = i_gnt_r;
  assign d_gnt  = d_gnt_r;
  assign w_gnt  = w_gnt_r;
  assign w_done = w_done_r;

  // IDs and responses are not used: single-ID master, BRESP/RRESP ignored.
  assign unused_ok_s = ^{axi.axi_s_i.rid, axi.axi_s_i.rresp,
                         axi.axi_s_i.bid, axi.axi_s_i.bresp};

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_axi_arbiter
// Directed self-checking bench for cache_axi_arbiter. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_cache_axi_arbiter;
  import cache_axi_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic [3:0]  i_len;
  logic        i_gnt;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_len;
  logic        d_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_owner;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_gnt;
  logic        w_done;

  int n_vec = 0;
  int n_err = 0;

  cache_axi_arbiter_if bus ();

  cache_axi_arbiter #(.LEN_W(4), .RR_INIT(1'b0)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_len    (i_len),
    .i_gnt    (i_gnt),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_len    (d_len),
    .d_gnt    (d_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rd_owner (rd_owner),
    .w_req    (w_req),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_strb   (w_strb),
    .w_gnt    (w_gnt),
    .w_done   (w_done),
    .axi      (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // AR handshake: one cycle of ARREADY, then the read is in its data phase.
  task automatic ar_hs(input string tag);
    bus.axi_s_i.arready = 1'b1;
    tick();
    bus.axi_s_i.arready = 1'b0;
    chk({tag, "_arvalid_low"}, 32'(bus.axi_m_o.arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(bus.axi_m_o.rready), 32'd1);
  endtask

  // Deliver n beats and check their forwarding; burst ends back in idle.
  task automatic beats(input int n, input logic [31:0] base, input logic owner, input string tag);
    for (int b = 0; b < n; b++) begin
      bus.axi_s_i.rvalid = 1'b1;
      bus.axi_s_i.rdata  = base + 32'(b);
      bus.axi_s_i.rlast  = (b == n - 1);
      #1;
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "_rd_data"}, rd_data, base + 32'(b));
      chk({tag, "_rd_last"}, 32'(rd_last), (b == n - 1) ? 32'd1 : 32'd0);
      chk({tag, "_rd_owner"}, 32'(rd_owner), 32'(owner));
      tick();
    end
    bus.axi_s_i.rvalid = 1'b0;
    bus.axi_s_i.rlast  = 1'b0;
    chk({tag, "_rready_idle"}, 32'(bus.axi_m_o.rready), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    i_req = 1'b0; i_addr = 32'h0; i_len = 4'h0;
    d_req = 1'b0; d_addr = 32'h0; d_len = 4'h0;
    w_req = 1'b0; w_addr = 32'h0; w_data = 32'h0; w_strb = 4'h0;
    bus.axi_s_i = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_arvalid", 32'(bus.axi_m_o.arvalid), 32'd0);
    chk("rst_awvalid", 32'(bus.axi_m_o.awvalid), 32'd0);
    chk("rst_wvalid", 32'(bus.axi_m_o.wvalid), 32'd0);
    chk("rst_bready", 32'(bus.axi_m_o.bready), 32'd0);
    chk("rst_rready", 32'(bus.axi_m_o.rready), 32'd0);
    chk("rst_w_done", 32'(w_done), 32'd0);
    resetn = 1'b1;
    tick();

    // ---------------- inst refill ----------------
    i_req = 1'b1; i_addr = 32'h1C00_0000; i_len = 4'd3;
    tick();
    i_req = 1'b0;
    chk("inst_i_gnt", 32'(i_gnt), 32'd1);
    chk("inst_d_gnt", 32'(d_gnt), 32'd0);
    chk("inst_arvalid", 32'(bus.axi_m_o.arvalid), 32'd1);
    chk("inst_araddr", bus.axi_m_o.araddr, 32'h1C00_0000);
    chk("inst_arlen", 32'(bus.axi_m_o.arlen), 32'd3);
    chk("inst_arsize", 32'(bus.axi_m_o.arsize), 32'd2);
    chk("inst_arburst", 32'(bus.axi_m_o.arburst), 32'd1);
    chk("inst_arid", 32'(bus.axi_m_o.arid), 32'd0);
    tick();
    chk("inst_gnt_pulse", 32'(i_gnt), 32'd0);
    chk("inst_arvalid_hold", 32'(bus.axi_m_o.arvalid), 32'd1);
    chk("inst_rready_ar", 32'(bus.axi_m_o.rready), 32'd0);
    ar_hs("inst");
    beats(4, 32'hA000_0000, 1'b0, "inst");

    // ---------------- tie arbitration ----------------
    i_req = 1'b1; i_addr = 32'h0000_0100; i_len = 4'd0;
    d_req = 1'b1; d_addr = 32'h0000_0200; d_len = 4'd0;
    tick();
    chk("tie1_d_gnt", 32'(d_gnt), 32'd1);
    chk("tie1_i_gnt", 32'(i_gnt), 32'd0);
    chk("tie1_araddr", bus.axi_m_o.araddr, 32'h0000_0200);
    d_addr = 32'h0000_0300;          // d_req stays high: a new request
    tick();
    chk("tie1_no_dup_d", 32'(d_gnt), 32'd0);
    chk("tie1_no_i_busy", 32'(i_gnt), 32'd0);
    ar_hs("tie1");
    beats(1, 32'hB000_0000, 1'b1, "tie1");
    tick();
    chk("tie2_i_gnt", 32'(i_gnt), 32'd1);
    chk("tie2_d_gnt", 32'(d_gnt), 32'd0);
    chk("tie2_araddr", bus.axi_m_o.araddr, 32'h0000_0100);
    i_req = 1'b0;
    ar_hs("tie2");
    beats(1, 32'hB100_0000, 1'b0, "tie2");
    tick();
    chk("lone_d_gnt", 32'(d_gnt), 32'd1);
    chk("lone_araddr", bus.axi_m_o.araddr, 32'h0000_0300);
    d_req = 1'b0;
    ar_hs("lone");
    beats(1, 32'hB200_0000, 1'b1, "lone");

    // ---------------- RAW hazard ----------------
    w_req = 1'b1; w_addr = 32'h8000_1004; w_data = 32'hDEAD_BEEF; w_strb = 4'hF;
    d_req = 1'b1; d_addr = 32'h8000_1004; d_len = 4'd0;
    tick();
    w_req = 1'b0;
    chk("raw_w_gnt", 32'(w_gnt), 32'd1);
    chk("raw_d_blocked0", 32'(d_gnt), 32'd0);
    chk("raw_awaddr", bus.axi_m_o.awaddr, 32'h8000_1004);
    chk("raw_wdata", bus.axi_m_o.wdata, 32'hDEAD_BEEF);
    chk("raw_wstrb", 32'(bus.axi_m_o.wstrb), 32'hF);
    chk("raw_wlast", 32'(bus.axi_m_o.wlast), 32'd1);
    chk("raw_awlen", 32'(bus.axi_m_o.awlen), 32'd0);
    tick();
    chk("raw_d_blocked1", 32'(d_gnt), 32'd0);
    bus.axi_s_i.awready = 1'b1; bus.axi_s_i.wready = 1'b1;
    tick();
    bus.axi_s_i.awready = 1'b0; bus.axi_s_i.wready = 1'b0;
    chk("raw_bready", 32'(bus.axi_m_o.bready), 32'd1);
    chk("raw_awvalid_low", 32'(bus.axi_m_o.awvalid), 32'd0);
    chk("raw_d_blocked2", 32'(d_gnt), 32'd0);
    bus.axi_s_i.bvalid = 1'b1;
    tick();
    bus.axi_s_i.bvalid = 1'b0;
    chk("raw_w_done", 32'(w_done), 32'd1);
    chk("raw_d_blocked3", 32'(d_gnt), 32'd0);
    tick();
    chk("raw_d_gnt_after", 32'(d_gnt), 32'd1);
    chk("raw_w_done_pulse", 32'(w_done), 32'd0);
    chk("raw_d_araddr", bus.axi_m_o.araddr, 32'h8000_1004);
    d_req = 1'b0;
    ar_hs("rawd");
    beats(1, 32'hC000_0000, 1'b1, "rawd");

    // different word: read and write captured together
    w_req = 1'b1; w_addr = 32'h8000_1004; w_data = 32'h0BAD_F00D; w_strb = 4'hF;
    d_req = 1'b1; d_addr = 32'h8000_1008; d_len = 4'd0;
    tick();
    w_req = 1'b0; d_req = 1'b0;
    chk("nohaz_w_gnt", 32'(w_gnt), 32'd1);
    chk("nohaz_d_gnt", 32'(d_gnt), 32'd1);
    chk("nohaz_araddr", bus.axi_m_o.araddr, 32'h8000_1008);
    bus.axi_s_i.arready = 1'b1; bus.axi_s_i.awready = 1'b1; bus.axi_s_i.wready = 1'b1;
    tick();
    bus.axi_s_i.arready = 1'b0; bus.axi_s_i.awready = 1'b0; bus.axi_s_i.wready = 1'b0;
    bus.axi_s_i.bvalid = 1'b1;
    beats(1, 32'hC100_0000, 1'b1, "nohaz");
    bus.axi_s_i.bvalid = 1'b0;
    chk("nohaz_w_done", 32'(w_done), 32'd1);

    // ---------------- write ready ordering ----------------
    tick();
    w_req = 1'b1; w_addr = 32'h0000_0040; w_data = 32'h1234_5678; w_strb = 4'h3;
    tick();
    w_req = 1'b0;
    chk("ord_w_gnt", 32'(w_gnt), 32'd1);
    bus.axi_s_i.wready = 1'b1;
    tick();
    bus.axi_s_i.wready = 1'b0;
    chk("ord_wvalid_first", 32'(bus.axi_m_o.wvalid), 32'd0);
    chk("ord_awvalid_hold", 32'(bus.axi_m_o.awvalid), 32'd1);
    chk("ord_bready_wait", 32'(bus.axi_m_o.bready), 32'd0);
    bus.axi_s_i.awready = 1'b1;
    tick();
    bus.axi_s_i.awready = 1'b0;
    chk("ord_awvalid_low", 32'(bus.axi_m_o.awvalid), 32'd0);
    chk("ord_bready", 32'(bus.axi_m_o.bready), 32'd1);
    tick();
    chk("ord_bready_hold", 32'(bus.axi_m_o.bready), 32'd1);
    chk("ord_no_done", 32'(w_done), 32'd0);
    bus.axi_s_i.bvalid = 1'b1;
    tick();
    bus.axi_s_i.bvalid = 1'b0;
    chk("ord_w_done", 32'(w_done), 32'd1);
    chk("ord_bready_low", 32'(bus.axi_m_o.bready), 32'd0);
    tick();
    chk("ord_w_done_pulse", 32'(w_done), 32'd0);

    // ---------------- overlap, ready held low ----------------
    i_req = 1'b1; i_addr = 32'h0000_1000; i_len = 4'd1;
    w_req = 1'b1; w_addr = 32'h0000_2000; w_data = 32'h0000_55AA; w_strb = 4'hF;
    tick();
    chk("ovl_i_gnt", 32'(i_gnt), 32'd1);
    chk("ovl_w_gnt", 32'(w_gnt), 32'd1);
    i_req = 1'b0; i_addr = 32'hFFFF_FFF0; i_len = 4'd9;
    w_req = 1'b0; w_addr = 32'hEEEE_EEE0; w_data = 32'h7777_7777;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ovl_araddr", bus.axi_m_o.araddr, 32'h0000_1000);
      chk("ovl_arlen", 32'(bus.axi_m_o.arlen), 32'd1);
      chk("ovl_arvalid", 32'(bus.axi_m_o.arvalid), 32'd1);
      chk("ovl_awaddr", bus.axi_m_o.awaddr, 32'h0000_2000);
      chk("ovl_wdata", bus.axi_m_o.wdata, 32'h0000_55AA);
      chk("ovl_awvalid", 32'(bus.axi_m_o.awvalid), 32'd1);
      chk("ovl_wvalid", 32'(bus.axi_m_o.wvalid), 32'd1);
      chk("ovl_no_dup_i", 32'(i_gnt), 32'd0);
      chk("ovl_no_dup_w", 32'(w_gnt), 32'd0);
    end
    bus.axi_s_i.awready = 1'b1; bus.axi_s_i.wready = 1'b1;
    ar_hs("ovl");
    bus.axi_s_i.awready = 1'b0; bus.axi_s_i.wready = 1'b0;
    bus.axi_s_i.bvalid = 1'b1;
    tick();
    bus.axi_s_i.bvalid = 1'b0;
    chk("ovl_w_done", 32'(w_done), 32'd1);
    beats(2, 32'hD000_0000, 1'b0, "ovl");

    // ---------------- mid-burst reset ----------------
    i_req = 1'b1; i_addr = 32'h0000_3000; i_len = 4'd7;
    w_req = 1'b1; w_addr = 32'h0000_5000; w_data = 32'h0000_0001; w_strb = 4'hF;
    tick();
    i_req = 1'b0; w_req = 1'b0;
    chk("mrst_i_gnt", 32'(i_gnt), 32'd1);
    ar_hs("mrst");
    bus.axi_s_i.rvalid = 1'b1; bus.axi_s_i.rdata = 32'hE000_0000;
    tick();
    bus.axi_s_i.rdata = 32'hE000_0001;
    #1;
    chk("mrst_beat2_valid", 32'(rd_valid), 32'd1);
    chk("mrst_awvalid_pre", 32'(bus.axi_m_o.awvalid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mrst_awvalid", 32'(bus.axi_m_o.awvalid), 32'd0);
    chk("mrst_wvalid", 32'(bus.axi_m_o.wvalid), 32'd0);
    chk("mrst_arvalid", 32'(bus.axi_m_o.arvalid), 32'd0);
    chk("mrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mrst_rready", 32'(bus.axi_m_o.rready), 32'd0);
    bus.axi_s_i.rvalid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    i_req = 1'b1; i_addr = 32'h0000_4000; i_len = 4'd0;
    tick();
    i_req = 1'b0;
    chk("post_i_gnt", 32'(i_gnt), 32'd1);
    chk("post_araddr", bus.axi_m_o.araddr, 32'h0000_4000);
    chk("post_arvalid", 32'(bus.axi_m_o.arvalid), 32'd1);
    ar_hs("post");
    beats(1, 32'hF000_0000, 1'b0, "post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
